center_buf_drain: RTL and testbench

Drain controller that sits directly downstream of the output center buffer. On a start command it reads a contiguous, wrap-around range of DATA_WIDTH-bit words from the buffer's read port, which has 1-cycle latency. It serializes each word into OUT_WIDTH-bit slices on a valid/ready output stream with backpressure. It flags the final slice of the final word and pulses `done` when the transfer completes.

---
 rtl/center_buf_drain.sv | 135 +++++++++++++
 tb/tb_center_buf_drain.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/center_buf_drain.sv
`default_nettype none
// center_buf_drain -- streams a wrap-around range of center-buffer words as OUT_WIDTH slices.
// Revision 1.0
module center_buf_drain #(
  parameter int DATA_WIDTH = 256,
  parameter int DEPTH      = 32,
  parameter int log2_DEPTH = 5,
  parameter int OUT_WIDTH  = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [log2_DEPTH-1:0]   start_base,
  input  logic [log2_DEPTH:0]     start_len,
  output logic                    rd_en,
  output logic [log2_DEPTH-1:0]   rd_addr,
  input  logic                    rd_dat_vld,
  input  logic [DATA_WIDTH-1:0]   rd_dat,
  output logic                    out_valid,
  output logic [OUT_WIDTH-1:0]    out_data,
  output logic                    out_last,
  input  logic                    out_ready,
  output logic                    busy,
  output logic                    done
);

  localparam int RATIO   = DATA_WIDTH / OUT_WIDTH;
  localparam int SLICE_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [SLICE_W-1:0]    LAST_SLICE = SLICE_W'(RATIO - 1);
  localparam logic [SLICE_W-1:0]    SLICE_ONE  = SLICE_W'(1);
  localparam logic [log2_DEPTH-1:0] ADDR_LAST  = log2_DEPTH'(DEPTH - 1);
  localparam logic [log2_DEPTH-1:0] ADDR_ONE   = log2_DEPTH'(1);
  localparam logic [log2_DEPTH:0]   LEN_ONE    = (log2_DEPTH + 1)'(1);

  typedef enum logic [2:0] {IDLE, READ, WAIT, SEND, DONE} state_t;

  state_t                  state, state_nxt;
  logic [log2_DEPTH-1:0]   cur_addr, cur_addr_nxt, addr_inc;
  logic [log2_DEPTH:0]     words_left, words_left_nxt;
  logic [SLICE_W-1:0]      slice, slice_nxt;
  logic [DATA_WIDTH-1:0]   hold_reg;
  logic                    load_hold;
  logic                    last_slice, last_word;
  logic [OUT_WIDTH-1:0]    slices [RATIO];

  for (genvar i = 0; i < RATIO; i++) begin : g_slice
    assign slices[i] = hold_reg[i*OUT_WIDTH +: OUT_WIDTH];
  end

  // Explicit wrap keeps the increment correct even if DEPTH were not a power of two.
  assign addr_inc   = (cur_addr == ADDR_LAST) ? '0 : cur_addr + ADDR_ONE;
  assign last_slice = (slice == LAST_SLICE);
  assign last_word  = (words_left == LEN_ONE);
  assign busy       = (state != IDLE);
  assign out_data   = (state == SEND) ? slices[slice] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cur_addr   <= '0;
      words_left <= '0;
      slice      <= '0;
      hold_reg   <= '0;
    end else begin
      state      <= state_nxt;
      cur_addr   <= cur_addr_nxt;
      words_left <= words_left_nxt;
      slice      <= slice_nxt;
      if (load_hold) hold_reg <= rd_dat;
    end
  end

  always_comb begin
    state_nxt      = state;
    cur_addr_nxt   = cur_addr;
    words_left_nxt = words_left;
    slice_nxt      = slice;
    load_hold      = 1'b0;
    rd_en          = 1'b0;
    rd_addr        = '0;
    out_valid      = 1'b0;
    out_last       = 1'b0;
    done           = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (start_len != '0) begin
            cur_addr_nxt   = start_base;
            words_left_nxt = start_len;
            state_nxt      = READ;
          end else begin
            state_nxt = DONE;
          end
        end
      end
      READ: begin
        rd_en     = 1'b1;
        rd_addr   = cur_addr;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (rd_dat_vld) begin
          load_hold = 1'b1;
          slice_nxt = '0;
          state_nxt = SEND;
        end
      end
      SEND: begin
        out_valid = 1'b1;
        out_last  = last_slice && last_word;
        if (out_ready) begin
          if (!last_slice) begin
            slice_nxt = slice + SLICE_ONE;
          end else if (last_word) begin
            state_nxt = DONE;
          end else begin
            // Next read overlaps the final handshake so only one bubble separates words.
            words_left_nxt = words_left - LEN_ONE;
            cur_addr_nxt   = addr_inc;
            rd_en          = 1'b1;
            rd_addr        = addr_inc;
            state_nxt      = WAIT;
          end
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_center_buf_drain.sv
`default_nettype none
// tb_center_buf_drain -- directed and randomized transfers checked against a slice-queue model.
module tb_center_buf_drain;

  localparam int DW    = 256;
  localparam int DEPTH = 32;
  localparam int AW    = 5;
  localparam int OW    = 64;
  localparam int RATIO = DW / OW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] start_base = '0;
  logic [AW:0]   start_len = '0;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic          rd_dat_vld = 1'b0;
  logic [DW-1:0] rd_dat = '0;
  logic          out_valid;
  logic [OW-1:0] out_data;
  logic          out_last;
  logic          out_ready = 1'b0;
  logic          busy;
  logic          done;

  int passed = 0;
  int total  = 0;
  logic [DW-1:0] mem [DEPTH];

  always #5 clk = ~clk;

  center_buf_drain #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .log2_DEPTH(AW), .OUT_WIDTH(OW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_base(start_base),
    .start_len(start_len), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_dat_vld(rd_dat_vld), .rd_dat(rd_dat), .out_valid(out_valid),
    .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
    .busy(busy), .done(done)
  );

  // Buffer read port: data returned one cycle after the request; junk strobes otherwise.
  always begin : resp
    logic          v;
    logic [AW-1:0] a;
    @(posedge clk);
    v = rd_en;
    a = rd_addr;
    #1;
    if (v) begin
      rd_dat_vld = 1'b1;
      rd_dat     = mem[a];
    end else begin
      rd_dat_vld = ($urandom_range(0, 3) == 0);
      rd_dat     = {8{$urandom()}};
    end
  end

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // mode: 0 ready high, 1 random ready, 2 three-cycle stall after two beats.
  // spur: 0 none, 1 extra start at cycle 4, 2 random extra starts.
  task automatic run_txn(input int base, input int len, input int mode, input int spur,
                         input int rst_cyc);
    logic [OW-1:0] exp_data [$];
    bit            exp_last [$];
    int            exp_addr [$];
    logic [DW-1:0] w;
    int            popped = 0;
    int            stall = 0;
    int            last_hs = -1;
    bit            prev_stall = 0;
    logic [OW-1:0] prev_data = '0;
    logic          prev_last = 1'b0;
    bit            fin = 0;

    for (int wi = 0; wi < len; wi++) begin
      int a;
      a = (base + wi) % DEPTH;
      exp_addr.push_back(a);
      w = mem[a];
      for (int s = 0; s < RATIO; s++) begin
        exp_data.push_back(w[s*OW +: OW]);
        exp_last.push_back(wi == len - 1 && s == RATIO - 1);
      end
    end

    for (int cyc = 0; !fin; cyc++) begin
      @(negedge clk);
      start = (cyc == 0) || (spur == 1 && cyc == 4) ||
              (spur == 2 && cyc > 0 && $urandom_range(0, 7) == 0);
      if (cyc == 0) begin
        start_base = AW'(base);
        start_len  = (AW+1)'(len);
      end else begin
        start_base = AW'($urandom());
        start_len  = (AW+1)'($urandom_range(0, DEPTH));
      end
      case (mode)
        0: out_ready = 1'b1;
        1: out_ready = ($urandom_range(0, 3) != 0);
        default: begin
          if (popped >= 2 && stall < 3) begin
            out_ready = 1'b0;
            stall++;
          end else begin
            out_ready = 1'b1;
          end
        end
      endcase

      if (rst_cyc > 0 && cyc == rst_cyc) begin
        rst_n = 1'b0;
        #1;
        chk("rst_mid_rd_en", rd_en, 0);
        chk("rst_mid_rd_addr", rd_addr, 0);
        chk("rst_mid_valid", out_valid, 0);
        chk("rst_mid_data", out_data, 0);
        chk("rst_mid_last", out_last, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_done", done, 0);
        @(negedge clk);
        start = 1'b0;
        #1;
        chk("rst_no_done", done, 0);
        chk("rst_idle_busy", busy, 0);
        rst_n = 1'b1;
        return;
      end

      #1;
      chk("busy", busy, (cyc != 0));
      if (cyc == 1 && len != 0) chk("first_rd_en", rd_en, 1);
      if (rd_en) begin
        if (exp_addr.size() == 0) chk("extra_rd", 1, 0);
        else chk("rd_addr", rd_addr, exp_addr.pop_front());
      end
      if (prev_stall) begin
        chk("stall_data", out_data, prev_data);
        chk("stall_last", out_last, prev_last);
      end
      if (out_valid) begin
        if (exp_data.size() == 0) begin
          chk("extra_beat", 1, 0);
        end else begin
          if (popped == 0 && mode == 0) chk("first_valid_cyc", cyc, 3);
          chk("out_data", out_data, exp_data[0]);
          chk("out_last", out_last, exp_last[0]);
          if (out_ready) begin
            void'(exp_data.pop_front());
            void'(exp_last.pop_front());
            popped++;
            last_hs = cyc;
          end
        end
      end else begin
        chk("last_idle", out_last, 0);
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;

      if (done) begin
        chk("beats_left", exp_data.size(), 0);
        chk("reads_left", exp_addr.size(), 0);
        chk("done_cyc", cyc, (len == 0) ? 1 : last_hs + 1);
        if (mode == 0) chk("done_cyc_nom", cyc, (len == 0) ? 1 : 2 + 5 * len);
        start = 1'b0;
        fin = 1;
      end else if (cyc > 3000) begin
        chk("timeout", 0, 1);
        start = 1'b0;
        fin = 1;
      end
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++)
      for (int j = 0; j < DW / 32; j++)
        mem[i][j*32 +: 32] = $urandom();
    mem[3] = {64'd4, 64'd3, 64'd2, 64'd1};

    repeat (3) @(negedge clk);
    #1;
    chk("rst_rd_en", rd_en, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst_n = 1'b1;

    run_txn(3, 1, 0, 0, 0);
    run_txn(31, 2, 0, 0, 0);
    run_txn(5, 3, 2, 0, 0);
    run_txn(7, 0, 0, 0, 0);
    run_txn(10, 2, 0, 1, 0);
    run_txn(12, 3, 0, 0, 4);
    run_txn(20, 1, 0, 0, 0);

    for (int t = 0; t < 20; t++)
      run_txn($urandom_range(0, DEPTH - 1), (t == 5) ? DEPTH : $urandom_range(0, 6),
              (t % 4 == 0) ? 0 : 1, 2, 0);

    @(negedge clk);
    #1;
    chk("busy_end", busy, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
